alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 3-bit alucontrol code produced by the ALU control decoder, together with two register operands and a shift amount.
- Logical, compare and add/sub operations complete in one cycle.
- Shift (code 110) runs as a serial one-bit-per-cycle shifter to save area.
- A start/busy/done handshake lets the datapath stall while a shift is in progress.

Parameters:
- WIDTH, 32, operand and result width in bits
- SHAMT_W, 5, shift-amount width in bits; must satisfy 2**SHAMT_W <= WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- alucontrol  input  3  operation code: 000 and, 001 or, 010 slt, 011 add, 100 sub, 101 nor, 110 sll, 111 reserved
- a  input  WIDTH  first operand (rs)
- b  input  WIDTH  second operand (rt or immediate); this is the shift source for sll
- shamt  input  SHAMT_W  shift amount
- result  output  WIDTH  registered result; holds until the next completion
- zero  output  1  registered; 1 when result == 0
- ovf  output  1  registered; signed overflow of add/sub, otherwise 0
- illegal  output  1  registered; 1 when the completed op used code 111
- busy  output  1  high while a serial shift is in progress
- done  output  1  one-cycle pulse when result, zero, ovf and illegal are updated

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; result=0, zero=1, ovf=0, illegal=0, busy=0, done=0; shift counter and accumulator cleared. Reset mid-shift aborts the operation and no done pulse is produced.
- States: IDLE, SHIFT.
- IDLE, start=0: outputs hold; done=0.
- IDLE, start=1, code != 110: operation is evaluated on the sampled inputs and registered at that edge, with done=1 for the next cycle and state staying IDLE. Latency is 1.
  - and/or/nor: bitwise.
  - slt: signed compare; result = {WIDTH-1 zeros, (a < b)}.
  - add/sub: modulo 2**WIDTH.
  - ovf = (sign(a) == sign(b') && sign(result) != sign(a)), where b' = b for add and ~b+1 for sub. ovf=0 for all other codes.
  - Code 111: result=0, illegal=1, done=1.
- IDLE, start=1, code 110:
  - shamt == 0: result=b and done=1 on that edge; latency 1; no busy.
  - shamt > 0: accumulator<=b, counter<=shamt, busy<=1, state<=SHIFT.
- SHIFT, each edge: accumulator<<=1 (zero fill) and counter decrements.
  - When the counter is 1 at an edge: result<=accumulator<<1, done<=1, busy<=0, state<=IDLE.
  - Total latency from the start edge to done is shamt cycles.
- Operand capture: a, b, shamt and alucontrol are captured at the start edge; later input changes do not affect an in-flight shift.
- start while busy=1 is ignored (not queued). The datapath must hold its request and re-issue it after done.
- start in the cycle where done=1 and busy=0 is accepted (back-to-back issue). done remains a single-cycle pulse per accepted operation.
- zero is always recomputed from the new result when done is produced. ovf and illegal are cleared on every completion that does not set them.
- Outputs (result, zero, ovf, illegal) change only on completion edges or on reset.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> result=0, zero=1, busy=0, done=0. Hold start=0 for 5 cycles -> no done pulse.
2. Single-cycle ops, issued back-to-back, each giving done=1 one cycle after start:
   - add a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1, zero=0
   - sub a=5, b=5 -> result=0, zero=1, ovf=0
   - slt a=0xFFFFFFFF, b=1 -> result=1
   - nor a=0, b=0 -> result=0xFFFFFFFF
3. Serial shift: code 110, b=0x00000003, shamt=4 -> busy=1 for 4 cycles, done pulse 4 cycles after start, result=0x00000030. A start asserted while busy, with different operands, is ignored and result is unchanged by it. shamt=0 with b=0xA5 -> result=0xA5 at latency 1, busy never high.
4. Boundary shift: b=0x80000001, shamt=31 -> done after 31 cycles, result=0x80000000.
5. Reset mid-shift: start sll with shamt=10, assert rst after 3 cycles -> busy=0, result=0, no done pulse. The next add a=2, b=3 -> result=5 at latency 1.
6. Reserved code: alucontrol=111 -> done=1, result=0, illegal=1, zero=1. A following add 1+1 -> illegal=0, result=2.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Purpose: request/response bundle between the datapath and the execution ALU.
// Ports: datapath side (master) drives start, alucontrol, a, b, shamt and samples the results;
//        ALU side (slave) returns result, zero, ovf, illegal, busy, done.
interface alu_exec_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         alucontrol;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               ovf;
  logic               illegal;
  logic               busy;
  logic               done;

  modport master (
    output start, alucontrol, a, b, shamt,
    input  result, zero, ovf, illegal, busy, done
  );

  modport slave (
    input  start, alucontrol, a, b, shamt,
    output result, zero, ovf, illegal, busy, done
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Purpose: execution-stage ALU; logical/compare/add/sub in one cycle, sll as a serial 1-bit/cycle shifter.
// Latency: 1 cycle for all ops except sll with shamt>0, which completes shamt cycles after the start edge.
// Backpressure: start is ignored while busy=1; the requester holds and re-issues after done.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries start/alucontrol/a/b/shamt in and
//        result/zero/ovf/illegal/busy/done out. All outputs are registered.
// SHAMT_W must satisfy 2**SHAMT_W <= WIDTH.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_unit_if.slave  bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_shl;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   result_reg;
  logic               zero_reg;
  logic               ovf_reg;
  logic               illegal_reg;
  logic               busy_reg;
  logic               done_reg;

  // Single-cycle evaluation of the current request
  logic [WIDTH-1:0]   op_res;
  logic               op_ovf;
  logic               op_ill;
  logic [WIDTH-1:0]   b_neg;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;

  assign acc_shl = {acc[WIDTH-2:0], 1'b0};

  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    op_ill = 1'b0;
    b_neg  = ~bus.b + WIDTH'(1);
    sum    = bus.a + bus.b;
    diff   = bus.a + b_neg;
    case (bus.alucontrol)
      OP_AND: op_res = bus.a & bus.b;
      OP_OR:  op_res = bus.a | bus.b;
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_ADD: begin
        op_res = sum;
        op_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        // Overflow judged against the two's-complement negated operand actually added
        op_res = diff;
        op_ovf = (bus.a[WIDTH-1] == b_neg[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NOR: op_res = ~(bus.a | bus.b);
      // Only reached for shamt == 0: the shift is the identity
      OP_SLL: op_res = bus.b;
      default: begin
        op_res = '0;
        op_ill = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      ovf_reg     <= 1'b0;
      illegal_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.alucontrol == OP_SLL && bus.shamt != '0) begin
              // Operands captured here; the serial shift never looks at the bus again
              acc      <= bus.b;
              cnt      <= bus.shamt;
              busy_reg <= 1'b1;
              state    <= SHIFT;
            end else begin
              result_reg  <= op_res;
              zero_reg    <= (op_res == '0);
              ovf_reg     <= op_ovf;
              illegal_reg <= op_ill;
              done_reg    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= acc_shl;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result_reg  <= acc_shl;
            zero_reg    <= (acc_shl == '0);
            ovf_reg     <= 1'b0;
            illegal_reg <= 1'b0;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result  = result_reg;
  assign bus.zero    = zero_reg;
  assign bus.ovf     = ovf_reg;
  assign bus.illegal = illegal_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Purpose: directed scoreboard bench for alu_exec_unit; driver pushes expectations, monitor pops on done.
// Latency: expected completion cycle is stored with each expectation and checked at the done pulse.
// Backpressure: exercises start-while-busy (ignored) and back-to-back issue on done.
module tb_alu_exec_unit;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;
    int          done_cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, ".result"},  bus.result,  mon_e.result);
        check({mon_e.name, ".zero"},    bus.zero,    mon_e.zero);
        check({mon_e.name, ".ovf"},     bus.ovf,     mon_e.ovf);
        check({mon_e.name, ".illegal"}, bus.illegal, mon_e.illegal);
        check({mon_e.name, ".cycle"},   cyc,         mon_e.done_cyc);
      end
    end
  end

  // Drive a request one cycle; extra = clock edges between the start edge and the done edge
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sh, input bit push, input int extra,
                       input logic [31:0] er, input logic ez, input logic eo, input logic ei,
                       input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.alucontrol = op;
    bus.a          = av;
    bus.b          = bv;
    bus.shamt      = sh;
    if (push) begin
      e.result   = er;
      e.zero     = ez;
      e.ovf      = eo;
      e.illegal  = ei;
      e.done_cyc = cyc + 1 + extra;
      e.name     = nm;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d completions outstanding, expected 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.alucontrol = 3'b000;
    bus.a          = '0;
    bus.b          = '0;
    bus.shamt      = '0;

    // 1. reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.result",  bus.result,  32'h0);
    check("reset.zero",    bus.zero,    1'b1);
    check("reset.ovf",     bus.ovf,     1'b0);
    check("reset.illegal", bus.illegal, 1'b0);
    check("reset.busy",    bus.busy,    1'b0);
    check("reset.done",    bus.done,    1'b0);
    repeat (5) @(posedge clk);

    // 2. single-cycle ops back-to-back
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 1, 0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf");
    issue(OP_SUB, 32'd5, 32'd5, 5'd0, 1, 0, 32'h0, 1'b1, 1'b0, 1'b0, "sub_zero");
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 1, 0, 32'h1, 1'b0, 1'b0, 1'b0, "slt_neg");
    issue(OP_NOR, 32'h0, 32'h0, 5'd0, 1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "nor_zero");
    issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1, 0, 32'hF000_F000, 1'b0, 1'b0, 1'b0, "and");
    issue(OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1, 0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, "or");
    issue(OP_SUB, 32'h8000_0000, 32'h1, 5'd0, 1, 0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, "sub_ovf");
    idle();
    drain("single");

    // 3. serial shift, with an ignored start while busy
    issue(OP_SLL, 32'h0, 32'h3, 5'd4, 1, 4, 32'h30, 1'b0, 1'b0, 1'b0, "sll4");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sll4.busy%0d", k), bus.busy, 1'b1);
      if (k == 0) begin
        bus.start      = 1'b1;
        bus.alucontrol = OP_ADD;
        bus.a          = 32'h1234;
        bus.b          = 32'hFFFF;
        bus.shamt      = 5'd7;
      end else begin
        bus.start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("sll4.busy_end", bus.busy, 1'b0);
    drain("sll4");

    issue(OP_SLL, 32'h0, 32'hA5, 5'd0, 1, 0, 32'hA5, 1'b0, 1'b0, 1'b0, "sll0");
    idle();
    check("sll0.busy", bus.busy, 1'b0);
    drain("sll0");

    // 4. boundary shift
    issue(OP_SLL, 32'h0, 32'h8000_0001, 5'd31, 1, 31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "sll31");
    idle();
    drain("sll31");

    // 5. reset mid-shift
    issue(OP_SLL, 32'h0, 32'h1, 5'd10, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0, "sll10");
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.busy",   bus.busy,   1'b0);
    check("midrst.result", bus.result, 32'h0);
    check("midrst.zero",   bus.zero,   1'b1);
    check("midrst.done",   bus.done,   1'b0);
    repeat (12) @(posedge clk);
    issue(OP_ADD, 32'd2, 32'd3, 5'd0, 1, 0, 32'd5, 1'b0, 1'b0, 1'b0, "add_after_rst");
    idle();
    drain("add_after_rst");

    // 6. reserved code then recovery
    issue(OP_RSV, 32'd5, 32'd6, 5'd0, 1, 0, 32'h0, 1'b1, 1'b0, 1'b1, "reserved");
    issue(OP_ADD, 32'd1, 32'd1, 5'd0, 1, 0, 32'd2, 1'b0, 1'b0, 1'b0, "add_after_rsv");
    idle();
    drain("reserved");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
